// File: rtl/axi_lite_copy_dma_if.sv
// AXI4-Lite master-side signal bundle for the copy engine.
// The master modport faces the engine; the slave modport faces the RAM or interconnect.
interface axi_lite_copy_dma_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] m_axi_awaddr;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;
   logic [DATA_WIDTH-1:0] m_axi_wdata;
   logic [STRB_WIDTH-1:0] m_axi_wstrb;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;
   logic [ADDR_WIDTH-1:0] m_axi_araddr;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;

   modport master (
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
             m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
             m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
   );

   modport slave (
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
             m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
             m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
   );
endinterface

// File: rtl/axi_lite_copy_dma.sv
// Single-channel AXI4-Lite word copy engine: read one word, write it, wait for the
// write response, advance; one transaction in flight, ascending addresses.
module axi_lite_copy_dma #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] len_words,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   axi_lite_copy_dma_if.master  m_axi
);
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR,
      S_WR_RESP,
      S_FINISH
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [LEN_WIDTH-1:0]  r_rem;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic w_ar_hs;
   logic w_r_hs;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_b_hs;
   logic w_aw_done;
   logic w_w_done;

   assign w_ar_hs   = r_arvalid & m_axi.m_axi_arready;
   assign w_r_hs    = r_rready  & m_axi.m_axi_rvalid;
   assign w_aw_hs   = r_awvalid & m_axi.m_axi_awready;
   assign w_w_hs    = r_wvalid  & m_axi.m_axi_wready;
   assign w_b_hs    = r_bready  & m_axi.m_axi_bvalid;
   // Address and data handshakes may complete in either order or together
   assign w_aw_done = r_aw_done | w_aw_hs;
   assign w_w_done  = r_w_done  | w_w_hs;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_rem     <= '0;
         r_data    <= '0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src   <= src_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
                  r_dst   <= dst_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
                  r_rem   <= len_words;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  if (len_words == '0) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (w_r_hs) begin
                  r_rready <= 1'b0;
                  r_data   <= m_axi.m_axi_rdata;
                  // A failed read aborts without writing that word
                  if (m_axi.m_axi_rresp != 2'b00) begin
                     r_error <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= S_WR;
                  end
               end
            end
            S_WR: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (w_b_hs) begin
                  r_bready <= 1'b0;
                  if (m_axi.m_axi_bresp != 2'b00) begin
                     r_error <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_src <= r_src + ADDR_WIDTH'(WORD_BYTES);
                     r_dst <= r_dst + ADDR_WIDTH'(WORD_BYTES);
                     r_rem <= r_rem - LEN_WIDTH'(1);
                     if (r_rem == LEN_WIDTH'(1)) begin
                        r_state <= S_FINISH;
                     end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_RD_ADDR;
                     end
                  end
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign error = r_error;

   assign m_axi.m_axi_araddr  = r_src;
   assign m_axi.m_axi_arvalid = r_arvalid;
   assign m_axi.m_axi_rready  = r_rready;
   assign m_axi.m_axi_awaddr  = r_dst;
   assign m_axi.m_axi_awvalid = r_awvalid;
   assign m_axi.m_axi_wdata   = r_data;
   assign m_axi.m_axi_wstrb   = {STRB_WIDTH{1'b1}};
   assign m_axi.m_axi_wvalid  = r_wvalid;
   assign m_axi.m_axi_bready  = r_bready;
endmodule

// File: doc/axi_lite_copy_dma.md
Name: axi_lite_copy_dma

Overview:
Single-channel AXI4-Lite master copy engine. It moves a block of 32-bit words from one region of the shared on-chip AXI4-Lite RAM to another, one word in flight at a time. It is configured and started by a simple start/status interface driven by the CPU-side register block. Its master port connects to the RAM slave port, either directly or through the interconnect.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 supported; word stride 4 bytes.
LEN_WIDTH, 16, width of the word-count input; max transfer 2^LEN_WIDTH-1 words.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  1-cycle request; accepted only in IDLE
src_addr  in  32  source byte address; bits[1:0] ignored (forced 0)
dst_addr  in  32  destination byte address; bits[1:0] ignored (forced 0)
len_words  in  LEN_WIDTH  number of words to copy
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at end of transfer (normal, zero-length or aborted)
error  out  1  sticky; set on any non-OKAY response; cleared on next accepted start
m_axi_awaddr  out  32  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  write strobes; always all ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  32  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; all valid/ready outputs 0; busy=0, done=0, error=0; address/count/data registers 0. Reset mid-transfer abandons the transfer immediately, with no completion and no done pulse.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, FINISH.
- IDLE:
  - start=1 latches src/dst (bits[1:0]=0) and len, and clears error.
  - If len=0, go to FINISH.
  - Otherwise go to RD_ADDR.
  - start outside IDLE is ignored.
- RD_ADDR: arvalid=1, araddr=cur_src. On arready&arvalid, drop arvalid and go to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid, capture rdata into the data register and drop rready.
  - If rresp!=00, set error and go to FINISH (no write for that word).
  - Otherwise go to WR.
- WR:
  - awvalid=1 and wvalid=1 are asserted in the same cycle. awaddr=cur_dst, wdata=the captured word.
  - Each valid drops independently on its own handshake.
  - Once both handshakes have completed (same or different cycles), go to WR_RESP.
- WR_RESP:
  - bready=1. On bvalid, drop bready.
  - If bresp!=00, set error and go to FINISH.
  - Otherwise: cur_src+=4, cur_dst+=4 (mod 2^32, wrap allowed), remaining-=1.
  - If remaining reaches 0, go to FINISH; else go to RD_ADDR.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=1 in FINISH and 0 in the following IDLE cycle.
- AXI rules:
  - A valid, once asserted, stays high with stable address/data until its handshake.
  - valid never waits on ready.
  - Each next phase asserts its valid in the cycle after the previous handshake; the engine inserts no extra idle cycles.
- Overlap: src/dst ranges may overlap; the copy always proceeds with ascending addresses, word by word (read word i, then write word i).
- Inputs src/dst/len are don't-care except in the cycle start is accepted.

Test Plan:
- Reset: hold resetn=0 for 3 cycles while start=1 -> all outputs 0, no AXI valids, busy=0.
- Basic copy: preload RAM[0x100..0x10C]={1,2,3,4}; start src=0x100, dst=0x200, len=4 -> RAM[0x200..0x20C]={1,2,3,4}; exactly 4 AR and 4 AW/W handshakes; done pulses once; error=0.
- Zero length: start len=0 -> done pulses 2 cycles after start; no arvalid/awvalid ever asserted.
- Backpressure: slave stalls awready 3 cycles and wready 1 cycle in a different cycle, random rvalid/bvalid delays 0-5 -> valids held stable, data still correct, start pulses during busy ignored.
- Error abort: slave returns rresp=2'b10 on word 2 of 4 -> word 1 written, no further AW, done pulses, error=1 sticky; next start clears error.
- Unaligned and wrap: start src=0x103, dst=0xFFFFFFFC, len=2 -> reads 0x100, 0x104; writes 0xFFFFFFFC, 0x00000000.
